// File: rtl/dom_rnd_gen.sv
// dom_rnd_gen: fresh-randomness source for the DOM-masked multiplier bank.
// K parallel 32-bit Galois LFSR lanes are seeded word by word, warmed up,
// and then released one word per accepted transfer.
//
// Handshakes: a transfer happens at a rising edge where valid and ready are
// both 1. Seed side: SeedReadyxSO is 1 only in SEED; SeedValidxSI outside it
// is ignored, never queued. Random side: RndValidxSO is 1 only in RUN; a word
// is consumed when RndReadyxSI=1, and the next word shows up one cycle later.
// Ready/valid outputs are decoded from registered state only.
module dom_rnd_gen #(
   parameter int SHARES                   = 2,
   parameter int FIRST_ORDER_OPTIMIZATION = 1,
   parameter int NUM_MULT                 = 8,
   parameter int STEPS_PER_CYCLE          = 32,
   parameter int WARMUP_CYCLES            = 4,
   localparam int ZW    = SHARES * (SHARES - 1),
   localparam int BW    = (FIRST_ORDER_OPTIMIZATION == 1 && SHARES == 2) ? 2 : 2 * SHARES,
   localparam int PER   = ZW + BW,
   localparam int RND_W = NUM_MULT * PER
) (
   input  logic             ClkxCI,
   input  logic             RstxRI,
   input  logic [31:0]      SeedxDI,
   input  logic             SeedValidxSI,
   output logic             SeedReadyxSO,
   input  logic             ReseedxSI,
   output logic [RND_W-1:0] RndxDO,
   output logic             RndValidxSO,
   input  logic             RndReadyxSI,
   output logic             BusyxSO
);

   localparam int K   = (RND_W + 31) / 32;
   localparam int LCW = (K > 1) ? $clog2(K) : 1;

   localparam logic [31:0]    POLY    = 32'h8020_0003;
   localparam logic [LCW-1:0] LC_LAST = LCW'(K - 1);
   localparam logic [7:0]     WC_LAST = (WARMUP_CYCLES > 0) ? 8'(WARMUP_CYCLES - 1) : 8'd0;

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } state_t;

   state_t            StatexDP, StatexDN;
   logic [LCW-1:0]    LcxDP, LcxDN;
   logic [7:0]        WcxDP, WcxDN;
   logic [31:0]       LanexDP [K];
   logic [31:0]       LanexDN [K];
   logic [32*K-1:0]   LanesPacked;

   // One advance: STEPS_PER_CYCLE unrolled Galois steps, purely combinational.
   function automatic logic [31:0] lfsrAdvance(input logic [31:0] s);
      logic [31:0] v;
      v = s;
      for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
         v = (v >> 1) ^ (v[0] ? POLY : 32'h0);
      end
      return v;
   endfunction

   // Next-state logic: reseed overrides both seed transfers and consumes.
   always_comb begin
      StatexDN = StatexDP;
      LcxDN    = LcxDP;
      WcxDN    = WcxDP;
      for (int k = 0; k < K; k++) begin
         LanexDN[k] = LanexDP[k];
      end

      if (ReseedxSI) begin
         StatexDN = SEED;
         LcxDN    = '0;
      end else begin
         case (StatexDP)
            SEED: begin
               if (SeedValidxSI) begin
                  // A zero seed is replaced by LC+1 so no lane can lock up at 0.
                  for (int k = 0; k < K; k++) begin
                     if (LcxDP == LCW'(k)) begin
                        LanexDN[k] = (SeedxDI == 32'h0) ? (32'(LcxDP) + 32'd1) : SeedxDI;
                     end
                  end
                  if (LcxDP == LC_LAST) begin
                     LcxDN    = '0;
                     WcxDN    = 8'd0;
                     StatexDN = (WARMUP_CYCLES > 0) ? WARMUP : RUN;
                  end else begin
                     LcxDN = LcxDP + LCW'(1);
                  end
               end
            end
            WARMUP: begin
               for (int k = 0; k < K; k++) begin
                  LanexDN[k] = lfsrAdvance(LanexDP[k]);
               end
               WcxDN = WcxDP + 8'd1;
               if (WcxDP == WC_LAST) begin
                  StatexDN = RUN;
               end
            end
            RUN: begin
               if (RndReadyxSI) begin
                  for (int k = 0; k < K; k++) begin
                     LanexDN[k] = lfsrAdvance(LanexDP[k]);
                  end
               end
            end
            default: begin
               StatexDN = SEED;
               LcxDN    = '0;
            end
         endcase
      end
   end

   // State, counters and lanes. After reset only lane 0 is nonzero so the
   // output reads 1; the other lanes are always overwritten before any advance.
   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         StatexDP <= SEED;
         LcxDP    <= '0;
         WcxDP    <= 8'd0;
         for (int k = 0; k < K; k++) begin
            LanexDP[k] <= (k == 0) ? 32'h0000_0001 : 32'h0;
         end
      end else begin
         StatexDP <= StatexDN;
         LcxDP    <= LcxDN;
         WcxDP    <= WcxDN;
         for (int k = 0; k < K; k++) begin
            LanexDP[k] <= LanexDN[k];
         end
      end
   end

   // Pack lanes with lane 0 in the LSBs; the output comes straight from flops.
   always_comb begin
      for (int k = 0; k < K; k++) begin
         LanesPacked[32*k +: 32] = LanexDP[k];
      end
   end

   assign RndxDO       = LanesPacked[RND_W-1:0];
   assign SeedReadyxSO = (StatexDP == SEED);
   assign RndValidxSO  = (StatexDP == RUN);
   assign BusyxSO      = (StatexDP != RUN);

endmodule

// File: tb/tb_dom_rnd_gen.sv
// Directed bench for dom_rnd_gen. Instance u0: defaults with single-step
// LFSR and no warmup (K=1). Instance u1: three shares, 32 steps, warmup 4 (K=3).
// Inputs change and outputs are checked on the falling edge.
module tb_dom_rnd_gen;

   logic clk;
   logic rst;

   // u0 signals
   logic [31:0] seed0;
   logic        sv0, sr0, reseed0, rv0, rr0, busy0;
   logic [31:0] rnd0;

   // u1 signals
   logic [31:0] seed1;
   logic        sv1, sr1, reseed1, rv1, rr1, busy1;
   logic [95:0] rnd1;

   int n_assert;
   int n_fail;

   logic [31:0] l [3];
   logic [31:0] fs;
   logic [95:0] hold1;

   dom_rnd_gen #(
      .SHARES(2), .FIRST_ORDER_OPTIMIZATION(1), .NUM_MULT(8),
      .STEPS_PER_CYCLE(1), .WARMUP_CYCLES(0)
   ) u0 (
      .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed0), .SeedValidxSI(sv0),
      .SeedReadyxSO(sr0), .ReseedxSI(reseed0), .RndxDO(rnd0),
      .RndValidxSO(rv0), .RndReadyxSI(rr0), .BusyxSO(busy0)
   );

   dom_rnd_gen #(
      .SHARES(3), .FIRST_ORDER_OPTIMIZATION(0), .NUM_MULT(8),
      .STEPS_PER_CYCLE(32), .WARMUP_CYCLES(4)
   ) u1 (
      .ClkxCI(clk), .RstxRI(rst), .SeedxDI(seed1), .SeedValidxSI(sv1),
      .SeedReadyxSO(sr1), .ReseedxSI(reseed1), .RndxDO(rnd1),
      .RndValidxSO(rv1), .RndReadyxSI(rr1), .BusyxSO(busy1)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // golden Galois LFSR, n single steps
   function automatic logic [31:0] adv(input logic [31:0] s, input int n);
      logic [31:0] v;
      v = s;
      for (int i = 0; i < n; i++) begin
         v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic seed_u0(input logic [31:0] w);
      seed0 = w;
      sv0   = 1'b1;
      tick();
      sv0   = 1'b0;
   endtask

   task automatic seed_u1(input logic [31:0] w);
      seed1 = w;
      sv1   = 1'b1;
      tick();
      sv1   = 1'b0;
   endtask

   task automatic chk_u1_lanes(input string tag);
      chk(tag, rnd1, {l[2], l[1], l[0]});
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b1;
      seed0 = '0; sv0 = 0; reseed0 = 0; rr0 = 0;
      seed1 = '0; sv1 = 0; reseed1 = 0; rr1 = 0;
      tick();
      tick();

      // reset values
      chk("u0_rst_rnd", rnd0, 96'h1);
      chk("u0_rst_valid", rv0, 0);
      chk("u0_rst_sready", sr0, 1);
      chk("u0_rst_busy", busy0, 1);
      chk("u1_rst_rnd_lane0", rnd1[31:0], 96'h1);
      chk("u1_rst_valid", rv1, 0);
      chk("u1_rst_sready", sr1, 1);
      chk("u1_rst_busy", busy1, 1);
      rst = 1'b0;
      tick();
      chk("u0_idle_valid", rv0, 0);

      // u0: zero seed becomes 1, valid one cycle later
      seed_u0(32'h0);
      chk("u0_zero_valid", rv0, 1);
      chk("u0_zero_rnd", rnd0, 96'h1);
      chk("u0_zero_busy", busy0, 0);
      chk("u0_zero_sready", sr0, 0);
      rr0 = 1'b1;
      tick();
      rr0 = 1'b0;
      chk("u0_step1", rnd0, 96'h8020_0003);

      // u0: backpressure with a stray seed that must be ignored
      seed0 = 32'hDEAD_BEEF;
      sv0   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("u0_hold_rnd", rnd0, 96'h8020_0003);
         chk("u0_hold_valid", rv0, 1);
      end
      sv0 = 1'b0;
      rr0 = 1'b1;
      tick();
      chk("u0_run_w1", rnd0, 96'hC030_0002);
      tick();
      chk("u0_run_w2", rnd0, 96'h6018_0001);
      tick();
      chk("u0_run_w3", rnd0, 96'hB02C_0003);
      rr0 = 1'b0;

      // u0: reseed keeps lanes, drops valid
      reseed0 = 1'b1;
      tick();
      reseed0 = 1'b0;
      chk("u0_reseed_valid", rv0, 0);
      chk("u0_reseed_sready", sr0, 1);
      chk("u0_reseed_busy", busy0, 1);
      chk("u0_reseed_keep", rnd0, 96'hB02C_0003);

      // u0: field mapping, Z and B per multiplier come from seed nibble m
      fs = 32'hA5A5_A5A5;
      seed_u0(fs);
      chk("u0_map_rnd", rnd0, {64'h0, fs});
      for (int m = 0; m < 8; m++) begin
         chk($sformatf("u0_map_z%0d", m), rnd0[4*m +: 2], fs[4*m +: 2]);
         chk($sformatf("u0_map_b%0d", m), rnd0[4*m+2 +: 2], fs[4*m+2 +: 2]);
      end

      // u1: multi-lane seeding with gaps, then warmup of 4
      seed_u1(32'd1);
      tick();
      chk("u1_seed_gap_busy", busy1, 1);
      chk("u1_seed_gap_sready", sr1, 1);
      seed_u1(32'd2);
      tick();
      tick();
      chk("u1_seed_gap2_valid", rv1, 0);
      seed_u1(32'd3);
      chk("u1_warm_sready", sr1, 0);
      for (int i = 0; i < 3; i++) begin
         chk("u1_warm_valid", rv1, 0);
         chk("u1_warm_busy", busy1, 1);
         tick();
      end
      chk("u1_warm_last_valid", rv1, 0);
      tick();
      chk("u1_seeded_valid", rv1, 1);
      chk("u1_seeded_busy", busy1, 0);
      l[0] = adv(32'd1, 128);
      l[1] = adv(32'd2, 128);
      l[2] = adv(32'd3, 128);
      chk_u1_lanes("u1_seeded_lanes");

      // u1: backpressure then three 32-step advances
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_u1_lanes("u1_hold_lanes");
         chk("u1_hold_valid", rv1, 1);
      end
      rr1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         for (int k = 0; k < 3; k++) l[k] = adv(l[k], 32);
         chk_u1_lanes("u1_run_lanes");
      end
      rr1 = 1'b0;

      // u1: reseed in the same cycle as a consume, no advance
      hold1   = {l[2], l[1], l[0]};
      rr1     = 1'b1;
      reseed1 = 1'b1;
      tick();
      rr1     = 1'b0;
      reseed1 = 1'b0;
      chk("u1_coll_valid", rv1, 0);
      chk("u1_coll_sready", sr1, 1);
      chk("u1_coll_busy", busy1, 1);
      chk("u1_coll_noadv", rnd1, hold1);
      seed_u1(32'd4);
      seed_u1(32'd0);
      seed_u1(32'd6);
      repeat (3) tick();
      chk("u1_reseed_warm_valid", rv1, 0);
      tick();
      chk("u1_reseed_valid", rv1, 1);
      l[0] = adv(32'd4, 128);
      l[1] = adv(32'd2, 128);
      l[2] = adv(32'd6, 128);
      chk_u1_lanes("u1_reseed_lanes");

      // u1: reset after one of three seed words
      reseed1 = 1'b1;
      tick();
      reseed1 = 1'b0;
      seed_u1(32'd7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("u1_mrst_rnd_lane0", rnd1[31:0], 96'h1);
      chk("u1_mrst_valid", rv1, 0);
      chk("u1_mrst_sready", sr1, 1);
      chk("u1_mrst_busy", busy1, 1);
      seed_u1(32'd8);
      seed_u1(32'd9);
      repeat (6) tick();
      chk("u1_mrst_partial_valid", rv1, 0);
      chk("u1_mrst_partial_sready", sr1, 1);
      seed_u1(32'd10);
      repeat (4) tick();
      chk("u1_mrst_valid_after", rv1, 1);
      l[0] = adv(32'd8, 128);
      l[1] = adv(32'd9, 128);
      l[2] = adv(32'd10, 128);
      chk_u1_lanes("u1_mrst_lanes");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
